multicycle_control_hs: RTL and testbench
========================================

# multicycle_control_hs

Multicycle RV32I controller with a memory ready handshake, intended to replace the fixed-latency multicycle controller in the multicycle core. The FSM decodes the opcode and sequences the datapath strobes (ALU, PC, IR, data register, regfile, memory) one state per cycle. It differs from the fixed-latency controller in four ways:
- it stalls in memory states until `mem_ready`;
- it adds JAL/JALR and full branch sequencing;
- it replaces undefined-opcode X-propagation with a sticky trap;
- it counts retired instructions.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 0: maximum stall cycles per memory access before trapping; 0 disables the timeout.
- `INSTRET_WIDTH`, default 32: width of the retired-instruction counter.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `inst_opcode`  in  7  opcode field of the IR.
- `branch_taken`  in  1  datapath branch comparison result; valid in BRANCH.
- `mem_ready`  in  1  memory has completed the current read or write this cycle.
- `alu_op_type`  out  3  ALU operation, using the `CTL_ALU_*` encodings.
- `alu_operand_a_select`  out  1  `CTL_ALU_A_PC` or `CTL_ALU_A_RS1`.
- `alu_operand_b_select`  out  2  `MC_CTL_ALU_B_4`, `MC_CTL_ALU_B_RS2` or `MC_CTL_ALU_B_IMM`.
- `next_pc_select`  out  2  `MC_CTL_PC_PC4`, `MC_CTL_PC_ALU` (live ALU result) or `MC_CTL_PC_ALU_OUT` (registered ALU result).
- `pc_write_enable`, `pc4_write_enable`, `alu_out_write_enable`, `inst_write_enable`, `data_write_enable`, `regfile_write_enable`  out  1 each  datapath register strobes.
- `mem_read_enable`, `mem_write_enable`  out  1 each  memory request, held until `mem_ready`.
- `reg_writeback_select`  out  2  `CTL_WRITEBACK_ALU`, `CTL_WRITEBACK_DATA`, `CTL_WRITEBACK_IMM` or `CTL_WRITEBACK_PC4`.
- `inst_or_data`  out  1  memory address source: 0 = PC, 1 = ALU out.
- `trap`  out  1  sticky fault flag.
- `trap_cause`  out  2  0 = none, 1 = illegal opcode, 2 = memory timeout, 3 = SYSTEM opcode.
- `instret`  out  `INSTRET_WIDTH`  retired-instruction count.

## Operation
- Defaults in every state:
  - All strobes and memory requests are 0.
  - All selects and `alu_op_type` are don't-care. The bench checks a select only in cycles where it is consumed.
- FETCH:
  - Asserts `mem_read_enable`, with `inst_or_data` = 0.
  - Drives ALU ADD of PC and 4.
  - `inst_write_enable` and `pc4_write_enable` are asserted only in the cycle where `mem_ready` = 1.
  - Moves to DECODE on `mem_ready`; otherwise stays in FETCH.
- DECODE:
  - Always asserts `alu_out_write_enable` with ADD of PC and IMM, computing the branch/JAL target.
  - Transitions by opcode:
    - LOAD or STORE → MEM_ADDR.
    - BRANCH → BRANCH.
    - OP → EXECUTE.
    - OP_IMM → EXECUTE_IMM.
    - LUI → EXECUTE_LUI.
    - AUIPC → EXECUTE_AUIPC.
    - JAL → JAL.
    - JALR → JALR.
    - MISC_MEM → FETCH. DECODE also asserts `pc_write_enable` with PC4 in this case (retires as a NOP).
    - SYSTEM → TRAP with cause 3.
    - Any other opcode → TRAP with cause 1.
- EXECUTE, EXECUTE_IMM, EXECUTE_AUIPC, ALU_WRITEBACK, EXECUTE_LUI and MEM_ADDR behave as in the existing multicycle controller.
- MEM_ADDR → MEM_READ for LOAD, → MEM_WRITE for STORE.
- MEM_READ:
  - Asserts `mem_read_enable`, with `inst_or_data` = 1.
  - `data_write_enable` is asserted only when `mem_ready` = 1.
  - Moves to MEM_WRITEBACK on `mem_ready`.
- MEM_WRITE:
  - Asserts `mem_write_enable`, with `inst_or_data` = 1.
  - When `mem_ready` = 1: asserts `pc_write_enable` with PC4, then moves to FETCH.
- BRANCH:
  - Drives `CTL_ALU_BRANCH` with RS1 and RS2, and asserts `pc_write_enable`.
  - `next_pc_select` = ALU_OUT if `branch_taken`, else PC4.
  - Next state is FETCH.
- JAL:
  - Asserts `regfile_write_enable` with `CTL_WRITEBACK_PC4`.
  - Asserts `pc_write_enable` with ALU_OUT.
  - Next state is FETCH.
- JALR:
  - Drives ALU ADD of RS1 and IMM.
  - Asserts `regfile_write_enable` with PC4 writeback.
  - Asserts `pc_write_enable` with ALU (the datapath clears bit 0).
  - Next state is FETCH.
- TRAP:
  - All strobes are 0 and `trap` = 1.
  - The state is absorbing; only `reset` exits it.
  - `trap_cause` is latched on entry.
- `instret` increments by 1 in every cycle where `pc_write_enable` = 1, and wraps modulo 2^`INSTRET_WIDTH`.
- Timeout (only when `MEM_TIMEOUT` > 0):
  - A stall counter of width clog2(`MEM_TIMEOUT`+1) clears on entry to FETCH, MEM_READ or MEM_WRITE.
  - It increments on each cycle of those states with `mem_ready` = 0.
  - If the count equals `MEM_TIMEOUT` and `mem_ready` = 0, the next state is TRAP with cause 2.
  - `mem_ready` = 1 in that same cycle wins: normal completion, no trap.

## Timing
- Reset:
  - While `reset` is high, all strobes, memory requests and `trap` are 0, `trap_cause` = 0 and `instret` = 0.
  - The state is FETCH.
  - First fetch request appears in the first cycle after deassertion.
- Latency with zero-wait memory (`mem_ready` always 1), in cycles:
  - OP, OP_IMM and AUIPC: 4.
  - LUI, BRANCH, JAL and JALR: 3.
  - LOAD: 5.
  - STORE: 4.
  - MISC_MEM: 2.
- Each memory wait cycle adds exactly 1 cycle.
- Request signals remain stable and asserted from the first request cycle through the `mem_ready` cycle. They drop in the cycle after `mem_ready`.
- Reset asserted mid-instruction (any state, including a wait state or TRAP) immediately forces the reset values. No pending strobe survives.

## Test plan
- ADDI with `mem_ready` always 1:
  - FETCH/DECODE/EXECUTE_IMM/ALU_WRITEBACK in 4 cycles.
  - `regfile_write_enable` = 1 in cycle 4 only.
  - `instret` goes 0 → 1.
- LW with `mem_ready` low for 3 cycles in MEM_READ:
  - `mem_read_enable` high for 4 cycles.
  - `data_write_enable` asserted once, in the cycle `mem_ready` rises.
  - Total 8 cycles.
- BEQ with `branch_taken` = 1, then again with `branch_taken` = 0:
  - `next_pc_select` = ALU_OUT, then PC4.
  - Each takes 3 cycles, and `pc_write_enable` pulses once each time.
- JAL, then JALR:
  - Writeback select is PC4 for both.
  - Next-PC is ALU_OUT for JAL and ALU for JALR.
  - `instret` advances by 2.
- `MEM_TIMEOUT` = 4, fetch with `mem_ready` held at 0:
  - TRAP is entered after 5 FETCH cycles, with `trap_cause` = 2.
  - A second run with `mem_ready` = 1 on the 5th cycle completes normally.
- Opcode 7'b1111111 → TRAP with cause 1; SYSTEM opcode → TRAP with cause 3.
  - The block stays in TRAP for 100 cycles with all strobes at 0.
  - Asserting `reset` clears `trap` and `instret` asynchronously.

Source files
------------

// File: rtl/multicycle_control_hs.sv
// Multicycle RV32I controller: one FSM state per cycle, memory ready handshake,
// optional memory timeout, sticky trap and a retired-instruction counter.
module multicycle_control_hs #(
    parameter int unsigned MEM_TIMEOUT   = 0,
    parameter int unsigned INSTRET_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [6:0]               inst_opcode,
    input  logic                     branch_taken,
    input  logic                     mem_ready,
    output logic [2:0]               alu_op_type,
    output logic                     alu_operand_a_select,
    output logic [1:0]               alu_operand_b_select,
    output logic [1:0]               next_pc_select,
    output logic                     pc_write_enable,
    output logic                     pc4_write_enable,
    output logic                     alu_out_write_enable,
    output logic                     inst_write_enable,
    output logic                     data_write_enable,
    output logic                     regfile_write_enable,
    output logic                     mem_read_enable,
    output logic                     mem_write_enable,
    output logic [1:0]               reg_writeback_select,
    output logic                     inst_or_data,
    output logic                     trap,
    output logic [1:0]               trap_cause,
    output logic [INSTRET_WIDTH-1:0] instret
);

    localparam logic [2:0] CTL_ALU_ADD    = 3'd0;
    localparam logic [2:0] CTL_ALU_OP     = 3'd1;
    localparam logic [2:0] CTL_ALU_OP_IMM = 3'd2;
    localparam logic [2:0] CTL_ALU_BRANCH = 3'd3;

    localparam logic CTL_ALU_A_PC  = 1'b0;
    localparam logic CTL_ALU_A_RS1 = 1'b1;

    localparam logic [1:0] MC_CTL_ALU_B_4   = 2'd0;
    localparam logic [1:0] MC_CTL_ALU_B_RS2 = 2'd1;
    localparam logic [1:0] MC_CTL_ALU_B_IMM = 2'd2;

    localparam logic [1:0] MC_CTL_PC_PC4     = 2'd0;
    localparam logic [1:0] MC_CTL_PC_ALU     = 2'd1;
    localparam logic [1:0] MC_CTL_PC_ALU_OUT = 2'd2;

    localparam logic [1:0] CTL_WRITEBACK_ALU  = 2'd0;
    localparam logic [1:0] CTL_WRITEBACK_DATA = 2'd1;
    localparam logic [1:0] CTL_WRITEBACK_IMM  = 2'd2;
    localparam logic [1:0] CTL_WRITEBACK_PC4  = 2'd3;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
    localparam logic [1:0] CAUSE_SYSTEM  = 2'd3;

    localparam int unsigned STALL_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WRITEBACK,
        S_MEM_WRITE,
        S_EXECUTE,
        S_EXECUTE_IMM,
        S_EXECUTE_AUIPC,
        S_EXECUTE_LUI,
        S_ALU_WRITEBACK,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_TRAP
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             cause_q, cause_d;
    logic [STALL_W-1:0]     stall_q, stall_d;
    logic [INSTRET_WIDTH-1:0] instret_q;
    logic                   mem_wait;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cause_q   <= '0;
            stall_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            stall_q <= stall_d;
            if (pc_write_enable) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    // Everything is decoded under !reset so an asserted reset forces all
    // strobes and requests low combinationally, mid-cycle included.
    always_comb begin
        state_d              = state_q;
        cause_d              = cause_q;
        stall_d              = '0;
        mem_wait             = 1'b0;
        alu_op_type          = CTL_ALU_ADD;
        alu_operand_a_select = CTL_ALU_A_PC;
        alu_operand_b_select = MC_CTL_ALU_B_4;
        next_pc_select       = MC_CTL_PC_PC4;
        pc_write_enable      = 1'b0;
        pc4_write_enable     = 1'b0;
        alu_out_write_enable = 1'b0;
        inst_write_enable    = 1'b0;
        data_write_enable    = 1'b0;
        regfile_write_enable = 1'b0;
        mem_read_enable      = 1'b0;
        mem_write_enable     = 1'b0;
        reg_writeback_select = CTL_WRITEBACK_ALU;
        inst_or_data         = 1'b0;
        trap                 = 1'b0;

        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read_enable      = 1'b1;
                    inst_or_data         = 1'b0;
                    alu_op_type          = CTL_ALU_ADD;
                    alu_operand_a_select = CTL_ALU_A_PC;
                    alu_operand_b_select = MC_CTL_ALU_B_4;
                    if (mem_ready) begin
                        inst_write_enable = 1'b1;
                        pc4_write_enable  = 1'b1;
                        state_d           = S_DECODE;
                    end else begin
                        mem_wait = 1'b1;
                    end
                end
                S_DECODE: begin
                    alu_out_write_enable = 1'b1;
                    alu_op_type          = CTL_ALU_ADD;
                    alu_operand_a_select = CTL_ALU_A_PC;
                    alu_operand_b_select = MC_CTL_ALU_B_IMM;
                    case (inst_opcode)
                        OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
                        OPC_BRANCH:          state_d = S_BRANCH;
                        OPC_OP:              state_d = S_EXECUTE;
                        OPC_OP_IMM:          state_d = S_EXECUTE_IMM;
                        OPC_LUI:             state_d = S_EXECUTE_LUI;
                        OPC_AUIPC:           state_d = S_EXECUTE_AUIPC;
                        OPC_JAL:             state_d = S_JAL;
                        OPC_JALR:            state_d = S_JALR;
                        OPC_MISC_MEM: begin
                            pc_write_enable = 1'b1;
                            next_pc_select  = MC_CTL_PC_PC4;
                            state_d         = S_FETCH;
                        end
                        OPC_SYSTEM: begin
                            state_d = S_TRAP;
                            cause_d = CAUSE_SYSTEM;
                        end
                        default: begin
                            state_d = S_TRAP;
                            cause_d = CAUSE_ILLEGAL;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_out_write_enable = 1'b1;
                    alu_op_type          = CTL_ALU_ADD;
                    alu_operand_a_select = CTL_ALU_A_RS1;
                    alu_operand_b_select = MC_CTL_ALU_B_IMM;
                    state_d              = (inst_opcode == OPC_STORE) ? S_MEM_WRITE : S_MEM_READ;
                end
                S_MEM_READ: begin
                    mem_read_enable = 1'b1;
                    inst_or_data    = 1'b1;
                    if (mem_ready) begin
                        data_write_enable = 1'b1;
                        state_d           = S_MEM_WRITEBACK;
                    end else begin
                        mem_wait = 1'b1;
                    end
                end
                S_MEM_WRITEBACK: begin
                    regfile_write_enable = 1'b1;
                    reg_writeback_select = CTL_WRITEBACK_DATA;
                    pc_write_enable      = 1'b1;
                    next_pc_select       = MC_CTL_PC_PC4;
                    state_d              = S_FETCH;
                end
                S_MEM_WRITE: begin
                    mem_write_enable = 1'b1;
                    inst_or_data     = 1'b1;
                    if (mem_ready) begin
                        pc_write_enable = 1'b1;
                        next_pc_select  = MC_CTL_PC_PC4;
                        state_d         = S_FETCH;
                    end else begin
                        mem_wait = 1'b1;
                    end
                end
                S_EXECUTE: begin
                    alu_out_write_enable = 1'b1;
                    alu_op_type          = CTL_ALU_OP;
                    alu_operand_a_select = CTL_ALU_A_RS1;
                    alu_operand_b_select = MC_CTL_ALU_B_RS2;
                    state_d              = S_ALU_WRITEBACK;
                end
                S_EXECUTE_IMM: begin
                    alu_out_write_enable = 1'b1;
                    alu_op_type          = CTL_ALU_OP_IMM;
                    alu_operand_a_select = CTL_ALU_A_RS1;
                    alu_operand_b_select = MC_CTL_ALU_B_IMM;
                    state_d              = S_ALU_WRITEBACK;
                end
                S_EXECUTE_AUIPC: begin
                    alu_out_write_enable = 1'b1;
                    alu_op_type          = CTL_ALU_ADD;
                    alu_operand_a_select = CTL_ALU_A_PC;
                    alu_operand_b_select = MC_CTL_ALU_B_IMM;
                    state_d              = S_ALU_WRITEBACK;
                end
                S_ALU_WRITEBACK: begin
                    regfile_write_enable = 1'b1;
                    reg_writeback_select = CTL_WRITEBACK_ALU;
                    pc_write_enable      = 1'b1;
                    next_pc_select       = MC_CTL_PC_PC4;
                    state_d              = S_FETCH;
                end
                S_EXECUTE_LUI: begin
                    regfile_write_enable = 1'b1;
                    reg_writeback_select = CTL_WRITEBACK_IMM;
                    pc_write_enable      = 1'b1;
                    next_pc_select       = MC_CTL_PC_PC4;
                    state_d              = S_FETCH;
                end
                S_BRANCH: begin
                    alu_op_type          = CTL_ALU_BRANCH;
                    alu_operand_a_select = CTL_ALU_A_RS1;
                    alu_operand_b_select = MC_CTL_ALU_B_RS2;
                    pc_write_enable      = 1'b1;
                    next_pc_select       = branch_taken ? MC_CTL_PC_ALU_OUT : MC_CTL_PC_PC4;
                    state_d              = S_FETCH;
                end
                S_JAL: begin
                    regfile_write_enable = 1'b1;
                    reg_writeback_select = CTL_WRITEBACK_PC4;
                    pc_write_enable      = 1'b1;
                    next_pc_select       = MC_CTL_PC_ALU_OUT;
                    state_d              = S_FETCH;
                end
                S_JALR: begin
                    alu_op_type          = CTL_ALU_ADD;
                    alu_operand_a_select = CTL_ALU_A_RS1;
                    alu_operand_b_select = MC_CTL_ALU_B_IMM;
                    regfile_write_enable = 1'b1;
                    reg_writeback_select = CTL_WRITEBACK_PC4;
                    pc_write_enable      = 1'b1;
                    next_pc_select       = MC_CTL_PC_ALU;
                    state_d              = S_FETCH;
                end
                S_TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            endcase

            // The counter only runs while a request waits; any exit from a
            // memory state (ready or trap) leaves it at zero for the next entry.
            if (mem_wait && (MEM_TIMEOUT != 0)) begin
                if (stall_q == STALL_MAX) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
        end
    end

    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_control_hs.sv
// Bench for multicycle_control_hs: vector table, hand-written corner sequences
// and randomized instruction streams against a latency/strobe-count model.
module tb_multicycle_control_hs;

    localparam logic [2:0] ALU_ADD = 3'd0, ALU_OP = 3'd1, ALU_OP_IMM = 3'd2;
    localparam logic       A_PC = 1'b0, A_RS1 = 1'b1;
    localparam logic [1:0] B_4 = 2'd0, B_RS2 = 2'd1, B_IMM = 2'd2;
    localparam int PC_PC4 = 0, PC_ALU = 1, PC_ALU_OUT = 2;
    localparam int WB_ALU = 0, WB_DATA = 1, WB_IMM = 2, WB_PC4 = 3;

    localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_MISC = 7'b0001111, OPC_OP_IMM = 7'b0010011,
                           OPC_AUIPC = 7'b0010111, OPC_STORE = 7'b0100011, OPC_OP = 7'b0110011,
                           OPC_LUI = 7'b0110111, OPC_BRANCH = 7'b1100011, OPC_JALR = 7'b1100111,
                           OPC_JAL = 7'b1101111, OPC_SYSTEM = 7'b1110011;

    logic clock = 1'b0;
    logic reset, branch_taken, mem_ready;
    logic [6:0] inst_opcode;
    logic [2:0] alu_op_type;
    logic alu_operand_a_select;
    logic [1:0] alu_operand_b_select, next_pc_select, reg_writeback_select, trap_cause;
    logic pc_write_enable, pc4_write_enable, alu_out_write_enable, inst_write_enable;
    logic data_write_enable, regfile_write_enable, mem_read_enable, mem_write_enable;
    logic inst_or_data, trap;
    logic [31:0] instret;

    logic t_reset, t_branch_taken, t_mem_ready;
    logic [6:0] t_inst_opcode;
    logic [2:0] t_alu_op_type;
    logic t_alu_operand_a_select;
    logic [1:0] t_alu_operand_b_select, t_next_pc_select, t_reg_writeback_select, t_trap_cause;
    logic t_pc_write_enable, t_pc4_write_enable, t_alu_out_write_enable, t_inst_write_enable;
    logic t_data_write_enable, t_regfile_write_enable, t_mem_read_enable, t_mem_write_enable;
    logic t_inst_or_data, t_trap;
    logic [2:0] t_instret;

    multicycle_control_hs dut (
        .clock(clock), .reset(reset), .inst_opcode(inst_opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .alu_op_type(alu_op_type), .alu_operand_a_select(alu_operand_a_select),
        .alu_operand_b_select(alu_operand_b_select), .next_pc_select(next_pc_select),
        .pc_write_enable(pc_write_enable), .pc4_write_enable(pc4_write_enable),
        .alu_out_write_enable(alu_out_write_enable), .inst_write_enable(inst_write_enable),
        .data_write_enable(data_write_enable), .regfile_write_enable(regfile_write_enable),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .reg_writeback_select(reg_writeback_select), .inst_or_data(inst_or_data),
        .trap(trap), .trap_cause(trap_cause), .instret(instret)
    );

    multicycle_control_hs #(.MEM_TIMEOUT(4), .INSTRET_WIDTH(3)) dut_to (
        .clock(clock), .reset(t_reset), .inst_opcode(t_inst_opcode), .branch_taken(t_branch_taken),
        .mem_ready(t_mem_ready), .alu_op_type(t_alu_op_type), .alu_operand_a_select(t_alu_operand_a_select),
        .alu_operand_b_select(t_alu_operand_b_select), .next_pc_select(t_next_pc_select),
        .pc_write_enable(t_pc_write_enable), .pc4_write_enable(t_pc4_write_enable),
        .alu_out_write_enable(t_alu_out_write_enable), .inst_write_enable(t_inst_write_enable),
        .data_write_enable(t_data_write_enable), .regfile_write_enable(t_regfile_write_enable),
        .mem_read_enable(t_mem_read_enable), .mem_write_enable(t_mem_write_enable),
        .reg_writeback_select(t_reg_writeback_select), .inst_or_data(t_inst_or_data),
        .trap(t_trap), .trap_cause(t_trap_cause), .instret(t_instret)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0] opc;
        logic       tk;
        int         cyc;
        int         rf;
        int         wb;
        int         npc;
    } vec_t;

    vec_t tbl[11];
    logic [6:0] legal_ops[10];
    int errors = 0;
    int checks = 0;
    int exp_instret = 0;
    logic [7:0] lw_rdy, lw_rd, lw_dw, lw_fin;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] strobes();
        return {pc_write_enable, pc4_write_enable, alu_out_write_enable, inst_write_enable,
                data_write_enable, regfile_write_enable, mem_read_enable, mem_write_enable};
    endfunction

    // Drives one instruction; fw/dw are the wait cycles inserted before the
    // fetch and data accesses complete. Ends after the cycle with pc_write_enable.
    task automatic run_instr(input logic [6:0] opc, input logic tk, input int fw, input int dw,
                             output int ncyc, output int nrf, output int rfcyc, output int wbs,
                             output int npc, output int nrd, output int nwr, output int ndw);
        int fl, dl;
        logic rdy, done;
        fl = fw; dl = dw;
        inst_opcode = opc; branch_taken = tk;
        ncyc = 0; nrf = 0; rfcyc = 0; wbs = -1; npc = -1; nrd = 0; nwr = 0; ndw = 0; done = 1'b0;
        while (!done && ncyc < 40) begin
            rdy = 1'($urandom_range(1, 0));
            if (mem_read_enable || mem_write_enable) begin
                rdy = 1'b1;
                if (!inst_or_data) begin
                    if (fl > 0) begin rdy = 1'b0; fl--; end
                end else if (dl > 0) begin
                    rdy = 1'b0; dl--;
                end
            end
            mem_ready = rdy;
            #1;
            ncyc++;
            if (regfile_write_enable) begin nrf++; rfcyc = ncyc; wbs = int'(reg_writeback_select); end
            if (mem_read_enable) nrd++;
            if (mem_write_enable) nwr++;
            if (data_write_enable) ndw++;
            if (pc_write_enable) begin npc = int'(next_pc_select); done = 1'b1; end
            @(negedge clock);
        end
    endtask

    function automatic int base_lat(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_AUIPC, OPC_STORE: return 4;
            OPC_LUI, OPC_BRANCH, OPC_JAL, OPC_JALR:  return 3;
            OPC_LOAD:                                return 5;
            OPC_MISC:                                return 2;
            default:                                 return 0;
        endcase
    endfunction

    function automatic int exp_wb(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_AUIPC: return WB_ALU;
            OPC_LUI:                       return WB_IMM;
            OPC_LOAD:                      return WB_DATA;
            OPC_JAL, OPC_JALR:             return WB_PC4;
            default:                       return -1;
        endcase
    endfunction

    function automatic int exp_npc(input logic [6:0] opc, input logic tk);
        if (opc == OPC_BRANCH) return tk ? PC_ALU_OUT : PC_PC4;
        if (opc == OPC_JAL) return PC_ALU_OUT;
        if (opc == OPC_JALR) return PC_ALU;
        return PC_PC4;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("reset_strobes", {24'd0, strobes()}, 32'd0);
        check("reset_trap", {30'd0, trap, trap_cause}, 32'd0);
        check("reset_instret", instret, 32'd0);
        exp_instret = 0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int ncyc, nrf, rfcyc, wbs, npc, nrd, nwr, ndw, bad;
        logic [6:0] opc;
        logic tk;
        int fw, dw, dwe;

        reset = 1'b1; t_reset = 1'b1;
        inst_opcode = OPC_OP_IMM; branch_taken = 1'b0; mem_ready = 1'b0;
        t_inst_opcode = OPC_OP_IMM; t_branch_taken = 1'b0; t_mem_ready = 1'b0;

        tbl[0]  = '{OPC_OP_IMM, 1'b0, 4, 1, WB_ALU,  PC_PC4};
        tbl[1]  = '{OPC_OP,     1'b0, 4, 1, WB_ALU,  PC_PC4};
        tbl[2]  = '{OPC_AUIPC,  1'b0, 4, 1, WB_ALU,  PC_PC4};
        tbl[3]  = '{OPC_LUI,    1'b0, 3, 1, WB_IMM,  PC_PC4};
        tbl[4]  = '{OPC_BRANCH, 1'b1, 3, 0, 0,       PC_ALU_OUT};
        tbl[5]  = '{OPC_BRANCH, 1'b0, 3, 0, 0,       PC_PC4};
        tbl[6]  = '{OPC_JAL,    1'b0, 3, 1, WB_PC4,  PC_ALU_OUT};
        tbl[7]  = '{OPC_JALR,   1'b1, 3, 1, WB_PC4,  PC_ALU};
        tbl[8]  = '{OPC_LOAD,   1'b0, 5, 1, WB_DATA, PC_PC4};
        tbl[9]  = '{OPC_STORE,  1'b0, 4, 0, 0,       PC_PC4};
        tbl[10] = '{OPC_MISC,   1'b0, 2, 0, 0,       PC_PC4};
        legal_ops = '{OPC_LOAD, OPC_MISC, OPC_OP_IMM, OPC_AUIPC, OPC_STORE,
                      OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL};
        lw_rdy = 8'b0100_0001;
        lw_rd  = 8'b0111_1001;
        lw_dw  = 8'b0100_0000;
        lw_fin = 8'b1000_0000;

        @(negedge clock);
        do_reset();

        // First cycle after reset: fetch request with a stalled memory.
        mem_ready = 1'b0; #1;
        check("fetch_req", {29'd0, mem_read_enable, inst_or_data, inst_write_enable}, 32'b100);
        check("fetch_alu", {26'd0, alu_op_type, alu_operand_a_select, alu_operand_b_select},
              {26'd0, ALU_ADD, A_PC, B_4});
        @(negedge clock);
        mem_ready = 1'b1; #1;
        check("fetch_done", {30'd0, inst_write_enable, pc4_write_enable}, 32'b11);
        @(negedge clock);
        mem_ready = 1'b0; #1;
        check("decode", {26'd0, alu_out_write_enable, alu_operand_a_select, alu_operand_b_select, pc_write_enable},
              {26'd0, 1'b1, A_PC, B_IMM, 1'b0});
        @(negedge clock);
        #1;
        check("exec_imm", {25'd0, alu_op_type, alu_operand_a_select, alu_operand_b_select, alu_out_write_enable},
              {25'd0, ALU_OP_IMM, A_RS1, B_IMM, 1'b1});
        check("exec_no_rf", {31'd0, regfile_write_enable}, 32'd0);
        @(negedge clock);
        #1;
        check("alu_wb", {28'd0, regfile_write_enable, pc_write_enable, reg_writeback_select},
              {28'd0, 1'b1, 1'b1, 2'(WB_ALU)});
        check("instret_before", instret, 32'd0);
        @(negedge clock);
        #1;
        check("instret_after", instret, 32'd1);
        exp_instret = 1;

        for (int i = 0; i < 11; i++) begin
            run_instr(tbl[i].opc, tbl[i].tk, 0, 0, ncyc, nrf, rfcyc, wbs, npc, nrd, nwr, ndw);
            exp_instret++;
            check($sformatf("tbl%0d_cycles", i), ncyc, tbl[i].cyc);
            check($sformatf("tbl%0d_rf", i), nrf, tbl[i].rf);
            if (tbl[i].rf != 0) begin
                check($sformatf("tbl%0d_wb", i), wbs, tbl[i].wb);
                check($sformatf("tbl%0d_rfcyc", i), rfcyc, tbl[i].cyc);
            end
            check($sformatf("tbl%0d_npc", i), npc, tbl[i].npc);
            check($sformatf("tbl%0d_instret", i), instret, exp_instret);
        end

        // LW with three wait cycles in the data read.
        inst_opcode = OPC_LOAD;
        dwe = 0;
        for (int i = 0; i < 8; i++) begin
            mem_ready = lw_rdy[i];
            #1;
            check($sformatf("lw_c%0d", i), {28'd0, mem_read_enable, data_write_enable, regfile_write_enable, pc_write_enable},
                  {28'd0, lw_rd[i], lw_dw[i], lw_fin[i], lw_fin[i]});
            if (i >= 3 && i <= 6) check($sformatf("lw_iod%0d", i), {31'd0, inst_or_data}, 32'd1);
            @(negedge clock);
        end
        exp_instret++;
        check("lw_instret", instret, exp_instret);

        // Randomized stream against the latency/strobe model.
        for (int n = 0; n < 150; n++) begin
            opc = legal_ops[$urandom_range(9, 0)];
            tk  = 1'($urandom_range(1, 0));
            fw  = int'($urandom_range(3, 0));
            dw  = int'($urandom_range(3, 0));
            run_instr(opc, tk, fw, dw, ncyc, nrf, rfcyc, wbs, npc, nrd, nwr, ndw);
            exp_instret++;
            check("rnd_cycles", ncyc, base_lat(opc) + fw + ((opc == OPC_LOAD || opc == OPC_STORE) ? dw : 0));
            check("rnd_reads", nrd, 1 + fw + ((opc == OPC_LOAD) ? 1 + dw : 0));
            check("rnd_writes", nwr, (opc == OPC_STORE) ? 1 + dw : 0);
            check("rnd_dwe", ndw, (opc == OPC_LOAD) ? 1 : 0);
            check("rnd_rf", nrf, (exp_wb(opc) >= 0) ? 1 : 0);
            check("rnd_wb", wbs, exp_wb(opc));
            check("rnd_npc", npc, exp_npc(opc, tk));
            check("rnd_instret", instret, exp_instret);
        end

        // Illegal opcode: sticky trap, strobes stay low, async reset clears it.
        inst_opcode = 7'b1111111;
        mem_ready = 1'b1; #1; @(negedge clock);
        #1;
        check("ill_decode_trap", {31'd0, trap}, 32'd0);
        @(negedge clock);
        #1;
        check("ill_trap", {29'd0, trap, trap_cause}, {29'd0, 1'b1, 2'd1});
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            mem_ready = 1'($urandom_range(1, 0));
            inst_opcode = 7'($urandom);
            #1;
            if (strobes() != 8'd0 || trap !== 1'b1 || trap_cause !== 2'd1) bad++;
            @(negedge clock);
        end
        check("trap_absorbing", bad, 0);
        check("trap_instret", instret, exp_instret);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_clear", {trap, trap_cause, instret[28:0]}, 32'd0);
        check("async_reset_instret", instret, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        inst_opcode = OPC_SYSTEM;
        mem_ready = 1'b1; #1; @(negedge clock);
        #1; @(negedge clock);
        #1;
        check("sys_trap", {29'd0, trap, trap_cause}, {29'd0, 1'b1, 2'd3});
        reset = 1'b1; #1; @(negedge clock);
        reset = 1'b0;

        // Reset during a fetch wait drops the request immediately.
        mem_ready = 1'b0; #1;
        check("wait_req", {31'd0, mem_read_enable}, 32'd1);
        #1; reset = 1'b1; #1;
        check("wait_reset", {24'd0, strobes()}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Timeout instance: five stalled fetch cycles then trap with cause 2.
        t_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            t_mem_ready = 1'b0; #1;
            check($sformatf("to_fetch%0d", i), {30'd0, t_mem_read_enable, t_trap}, 32'b10);
            @(negedge clock);
        end
        #1;
        check("to_trap", {28'd0, t_trap, t_mem_read_enable, t_trap_cause}, {28'd0, 1'b1, 1'b0, 2'd2});
        t_reset = 1'b1; #1;
        check("to_reset", {29'd0, t_trap, t_trap_cause}, 32'd0);
        @(negedge clock);
        t_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            t_mem_ready = (i == 4); #1;
            if (i == 4) check("to_ready_last", {31'd0, t_inst_write_enable}, 32'd1);
            @(negedge clock);
        end
        #1;
        check("to_no_trap", {30'd0, t_trap, t_alu_out_write_enable}, 32'b01);
        @(negedge clock); @(negedge clock); #1;
        check("to_instr_done", {31'd0, t_pc_write_enable}, 32'd1);
        @(negedge clock); #1;
        check("to_instret1", t_instret, 32'd1);
        t_inst_opcode = OPC_MISC;
        t_mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock); @(negedge clock); #1;
            if (i == 6) check("wrap_zero", t_instret, 32'd0);
        end
        check("wrap_one", t_instret, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
